reg_monitor: RTL and testbench

Debug front-panel stage that sits directly downstream of the CPU's register observation bus and upstream of its admin write port. It consumes the 160-bit `oreg` snapshot (five 32-bit register slots) and scans one selected slot onto an 8-digit multiplexed seven-segment display. It debounces three push-buttons and stages a 32-bit value from slide switches. When the CPU grants admin access, it presents that staged value with a target register index on `reg_i`/`reg_input`.

---
 rtl/reg_monitor.sv | 246 ++++++++++++++++++++++++
 tb/tb_reg_monitor.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_monitor.sv
// reg_monitor
// Debug front panel between the CPU register observation bus and its admin
// write port. Scans one selected 32-bit register slot (or the staged word, or
// the last committed word) onto an 8-digit multiplexed seven-segment display,
// debounces three push-buttons, and stages a 32-bit value from slide switches
// that is committed to the CPU when admin access is granted.
//
// Ports:
//   clk            single rising-edge clock
//   rst            synchronous active-high reset
//   oreg           NUM_REGS packed 32-bit register slots, slot k at [32k+31:32k]
//   reg_admin_ena  CPU grants admin writes when 1 (sampled on the write pulse)
//   btn_next       raw button: select next slot / leave STAGE or ACK view
//   btn_load       raw button: shift sw_data into the stage register
//   btn_write      raw button: commit the stage register to the CPU
//   sw_data        16-bit switch data
//   sw_addr        target register index for a commit
//   reg_i          committed register index
//   reg_input      committed data word
//   an             digit enables, active-low, one-hot
//   seg            segments {dp,g,f,e,d,c,b,a}, active-low
//   led_err        last write attempt was refused
module reg_monitor #(
    parameter int NUM_REGS        = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SCAN_CYCLES     = 100000,
    parameter int ACK_CYCLES      = 50000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REGS*32-1:0]   oreg,
    input  logic                     reg_admin_ena,
    input  logic                     btn_next,
    input  logic                     btn_load,
    input  logic                     btn_write,
    input  logic [15:0]              sw_data,
    input  logic [4:0]               sw_addr,
    output logic [4:0]               reg_i,
    output logic [31:0]              reg_input,
    output logic [7:0]               an,
    output logic [7:0]               seg,
    output logic                     led_err
);

    localparam int SEL_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SCAN_W = $clog2(SCAN_CYCLES + 1);
    localparam int ACK_W  = $clog2(ACK_CYCLES + 1);

    typedef enum logic [1:0] {
        MODE_REG   = 2'd0,
        MODE_STAGE = 2'd1,
        MODE_ACK   = 2'd2
    } mode_t;

    // Active-high {g,f,e,d,c,b,a} pattern for one hex digit; inverted at the pins.
    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    // Button bit order: 0 = next, 1 = load, 2 = write.
    logic [2:0]      btn_raw;
    logic [2:0]      sync_a;
    logic [2:0]      sync_b;
    logic [2:0]      level;
    logic [2:0]      level_q;
    logic [2:0]      pulse;
    logic [DB_W-1:0] db_cnt [3];

    logic p_next;
    logic p_load;
    logic p_write;

    assign btn_raw = {btn_write, btn_load, btn_next};
    assign p_next  = pulse[0];
    assign p_load  = pulse[1];
    assign p_write = pulse[2];

    // Two-flop synchronizer followed by an integrating debouncer per button.
    // The counter only runs while the synchronized input disagrees with the
    // debounced level, so any bounce back to the old level restarts it. The
    // rising edge of the debounced level is turned into a one-cycle pulse one
    // cycle later, so a held button can never pulse twice.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a  <= '0;
            sync_b  <= '0;
            level   <= '0;
            level_q <= '0;
            pulse   <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_a  <= btn_raw;
            sync_b  <= sync_a;
            level_q <= level;
            pulse   <= level & ~level_q;
            for (int i = 0; i < 3; i++) begin
                if (sync_b[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_cnt[i] <= '0;
                    level[i]  <= ~level[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    mode_t            state, state_n;
    logic [SEL_W-1:0] sel, sel_n;
    logic [31:0]      stage, stage_n;
    logic [4:0]       reg_i_n;
    logic [31:0]      reg_input_n;
    logic             led_err_n;
    logic [ACK_W-1:0] ack_cnt, ack_cnt_n;

    // Mode and data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MODE_REG;
            sel       <= '0;
            stage     <= '0;
            reg_i     <= '0;
            reg_input <= '0;
            led_err   <= 1'b0;
            ack_cnt   <= '0;
        end else begin
            state     <= state_n;
            sel       <= sel_n;
            stage     <= stage_n;
            reg_i     <= reg_i_n;
            reg_input <= reg_input_n;
            led_err   <= led_err_n;
            ack_cnt   <= ack_cnt_n;
        end
    end

    // Next-state logic. Every pulse applies its own data update, while the
    // mode transition follows write > load > next. A commit captures the
    // stage register as it was before any same-cycle load shifts it. A
    // refused write only raises led_err and leaves the mode alone.
    always_comb begin
        state_n     = state;
        sel_n       = sel;
        stage_n     = stage;
        reg_i_n     = reg_i;
        reg_input_n = reg_input;
        led_err_n   = led_err;
        ack_cnt_n   = ack_cnt;

        if (p_next) begin
            sel_n = (sel == SEL_W'(NUM_REGS - 1)) ? '0 : sel + 1'b1;
        end
        if (p_load) begin
            stage_n = {stage[15:0], sw_data};
        end

        if (state == MODE_ACK) begin
            if (ack_cnt >= ACK_W'(ACK_CYCLES - 1)) begin
                state_n = MODE_REG;
            end else begin
                ack_cnt_n = ack_cnt + 1'b1;
            end
        end

        if (p_write) begin
            if (reg_admin_ena) begin
                reg_i_n     = sw_addr;
                reg_input_n = stage;
                led_err_n   = 1'b0;
                state_n     = MODE_ACK;
                ack_cnt_n   = '0;
            end else begin
                led_err_n = 1'b1;
                state_n   = state;
            end
        end else if (p_load) begin
            state_n = (state == MODE_ACK) ? MODE_ACK : MODE_STAGE;
        end else if (p_next) begin
            state_n = MODE_REG;
        end
    end

    logic [31:0]       slots [NUM_REGS];
    logic [31:0]       shown;
    logic [2:0]        digit;
    logic [SCAN_W-1:0] scan_cnt;

    // Unpack the snapshot bus and pick the word the current mode displays.
    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) begin
            slots[k] = oreg[32*k +: 32];
        end
        shown = slots[sel];
        case (state)
            MODE_STAGE: shown = stage;
            MODE_ACK:   shown = reg_input;
            default:    shown = slots[sel];
        endcase
    end

    // Digit scan: each digit stays lit for SCAN_CYCLES, then wraps 7 -> 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            digit    <= '0;
        end else if (scan_cnt == SCAN_W'(SCAN_CYCLES - 1)) begin
            scan_cnt <= '0;
            digit    <= digit + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Registered pin drivers; the decimal point marks the acknowledge view.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 8'b1111_1110;
            seg <= {1'b1, ~hex_glyph(oreg[3:0])};
        end else begin
            an  <= ~(8'b1 << digit);
            seg <= {state != MODE_ACK, ~hex_glyph(shown[4*digit +: 4])};
        end
    end

endmodule

// File: tb/tb_reg_monitor.sv
// tb_reg_monitor
// Self-checking bench for reg_monitor. Buttons are pressed as whole events
// and an event-level model of the panel predicts the selected slot, stage
// word, mode and committed outputs; the display is captured over a full scan
// and compared digit by digit against glyphs of the predicted word.
module tb_reg_monitor;

    localparam int NR = 5;
    localparam int DB = 4;
    localparam int SC = 2;
    localparam int AK = 80;

    localparam int M_REG   = 0;
    localparam int M_STAGE = 1;
    localparam int M_ACK   = 2;

    logic            clk;
    logic            rst;
    logic [NR*32-1:0] oreg;
    logic            reg_admin_ena;
    logic [2:0]      btn;
    logic [15:0]     sw_data;
    logic [4:0]      sw_addr;
    logic [4:0]      reg_i;
    logic [31:0]     reg_input;
    logic [7:0]      an;
    logic [7:0]      seg;
    logic            led_err;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int          m_sel;
    logic [31:0] m_stage;
    int          m_mode;
    logic [4:0]  m_reg_i;
    logic [31:0] m_reg_input;
    logic        m_led_err;

    // Active-low {dp,g..a} glyphs with dp off.
    logic [7:0] glyph_lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    reg_monitor #(
        .NUM_REGS(NR),
        .DEBOUNCE_CYCLES(DB),
        .SCAN_CYCLES(SC),
        .ACK_CYCLES(AK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .oreg(oreg),
        .reg_admin_ena(reg_admin_ena),
        .btn_next(btn[0]),
        .btn_load(btn[1]),
        .btn_write(btn[2]),
        .sw_data(sw_data),
        .sw_addr(sw_addr),
        .reg_i(reg_i),
        .reg_input(reg_input),
        .an(an),
        .seg(seg),
        .led_err(led_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void model_reset();
        m_sel       = 0;
        m_stage     = '0;
        m_mode      = M_REG;
        m_reg_i     = '0;
        m_reg_input = '0;
        m_led_err   = 1'b0;
    endfunction

    // One button event (mask bit 0 next, 1 load, 2 write) applied to the model.
    function automatic void model_press(input logic [2:0] mask);
        logic [31:0] old_stage;
        old_stage = m_stage;
        if (mask[0]) m_sel = (m_sel + 1) % NR;
        if (mask[1]) m_stage = {m_stage[15:0], sw_data};
        if (mask[2]) begin
            if (reg_admin_ena) begin
                m_reg_i     = sw_addr;
                m_reg_input = old_stage;
                m_led_err   = 1'b0;
                m_mode      = M_ACK;
            end else begin
                m_led_err = 1'b1;
            end
        end else if (mask[1]) begin
            m_mode = (m_mode == M_ACK) ? M_ACK : M_STAGE;
        end else if (mask[0]) begin
            m_mode = M_REG;
        end
    endfunction

    function automatic logic [63:0] expected_segs();
        logic [31:0] w;
        logic [63:0] r;
        logic [7:0]  s;
        case (m_mode)
            M_STAGE: w = m_stage;
            M_ACK:   w = m_reg_input;
            default: w = oreg[32*m_sel +: 32];
        endcase
        for (int i = 0; i < 8; i++) begin
            s = glyph_lut[w[4*i +: 4]];
            if (m_mode == M_ACK) s[7] = 1'b0;
            r[8*i +: 8] = s;
        end
        return r;
    endfunction

    function automatic logic [37:0] expected_outs();
        return {m_reg_i, m_reg_input, m_led_err};
    endfunction

    // Records the segment pattern seen for each lit digit across a full scan.
    task automatic capture_display(output logic [63:0] segs, output int bad);
        int found;
        segs = '0;
        bad  = 0;
        repeat (8*SC + 4) begin
            @(negedge clk);
            found = -1;
            for (int i = 0; i < 8; i++) begin
                if (an == ~(8'b1 << i)) found = i;
            end
            if (found < 0) bad++;
            else segs[8*found +: 8] = seg;
        end
    endtask

    // Press the buttons in mask together, optionally preceded by a 1-cycle glitch.
    task automatic press(input logic [2:0] mask, input bit glitch, input int hold);
        if (glitch) begin
            @(negedge clk);
            btn = mask;
            @(negedge clk);
            btn = 3'b000;
            repeat (8) @(negedge clk);
        end
        @(negedge clk);
        btn = mask;
        repeat (hold) @(negedge clk);
        btn = 3'b000;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] exp_an;
        logic [63:0] segs;
        int bad;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        checks++;
        if ({reg_i, reg_input, led_err} !== 38'd0) begin
            errors++;
            $display("[TB] FAIL reset_outs: got %h expected 0", {reg_i, reg_input, led_err});
        end
        checks++;
        if (an !== 8'hFE) begin
            errors++;
            $display("[TB] FAIL reset_an: got %h expected fe", an);
        end
        checks++;
        if (seg !== glyph_lut[4'hD]) begin
            errors++;
            $display("[TB] FAIL reset_seg: got %h expected %h", seg, glyph_lut[4'hD]);
        end
        rst = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            exp_an = ~(8'b1 << (((j - 1) / SC) % 8));
            checks++;
            if (an !== exp_an) begin
                errors++;
                $display("[TB] FAIL an_walk[%0d]: got %h expected %h", j, an, exp_an);
            end
        end
        capture_display(segs, bad);
        checks++;
        if (segs !== expected_segs() || bad != 0) begin
            errors++;
            $display("[TB] FAIL reset_display: got %h (bad=%0d) expected %h", segs, bad, expected_segs());
        end
    endtask

    task automatic test_next_glitch();
        logic [63:0] segs;
        int bad;
        for (int p = 0; p < 5; p++) begin
            press(3'b001, 1'b1, 10);
            model_press(3'b001);
            capture_display(segs, bad);
            checks++;
            if (segs !== expected_segs() || bad != 0) begin
                errors++;
                $display("[TB] FAIL next_sel%0d: got %h (bad=%0d) expected %h", m_sel, segs, bad, expected_segs());
            end
        end
    endtask

    task automatic test_load_stage();
        logic [63:0] segs;
        int bad;
        logic [15:0] halves [2] = '{16'hDEAD, 16'hBEEF};
        for (int h = 0; h < 2; h++) begin
            sw_data = halves[h];
            press(3'b010, 1'b0, 10);
            model_press(3'b010);
            capture_display(segs, bad);
            checks++;
            if (segs !== expected_segs() || bad != 0) begin
                errors++;
                $display("[TB] FAIL load_%0d: got %h (bad=%0d) expected %h", h, segs, bad, expected_segs());
            end
        end
    endtask

    task automatic test_write_ack();
        logic [63:0] segs;
        int bad;
        reg_admin_ena = 1'b1;
        sw_addr = 5'd7;
        press(3'b100, 1'b0, 10);
        model_press(3'b100);
        checks++;
        if ({reg_i, reg_input, led_err} !== expected_outs()) begin
            errors++;
            $display("[TB] FAIL write_outs: got %h expected %h", {reg_i, reg_input, led_err}, expected_outs());
        end
        capture_display(segs, bad);
        checks++;
        if (segs !== expected_segs() || bad != 0) begin
            errors++;
            $display("[TB] FAIL ack_display: got %h (bad=%0d) expected %h", segs, bad, expected_segs());
        end
        repeat (AK) @(negedge clk);
        m_mode = M_REG;
        capture_display(segs, bad);
        checks++;
        if (segs !== expected_segs() || bad != 0) begin
            errors++;
            $display("[TB] FAIL ack_expire: got %h (bad=%0d) expected %h", segs, bad, expected_segs());
        end
    endtask

    task automatic test_refused();
        logic [63:0] segs;
        int bad;
        reg_admin_ena = 1'b0;
        sw_addr = 5'd3;
        press(3'b100, 1'b0, 10);
        model_press(3'b100);
        checks++;
        if ({reg_i, reg_input, led_err} !== expected_outs()) begin
            errors++;
            $display("[TB] FAIL refused_outs: got %h expected %h", {reg_i, reg_input, led_err}, expected_outs());
        end
        capture_display(segs, bad);
        checks++;
        if (segs !== expected_segs() || bad != 0) begin
            errors++;
            $display("[TB] FAIL refused_display: got %h (bad=%0d) expected %h", segs, bad, expected_segs());
        end
        reg_admin_ena = 1'b1;
        sw_addr = 5'd12;
        press(3'b100, 1'b0, 10);
        model_press(3'b100);
        checks++;
        if ({reg_i, reg_input, led_err} !== expected_outs()) begin
            errors++;
            $display("[TB] FAIL regrant_outs: got %h expected %h", {reg_i, reg_input, led_err}, expected_outs());
        end
        repeat (AK + 10) @(negedge clk);
        m_mode = M_REG;
    endtask

    task automatic test_ack_buttons();
        logic [63:0] segs;
        int bad;
        reg_admin_ena = 1'b1;
        sw_addr = 5'd21;
        press(3'b100, 1'b0, 10);
        model_press(3'b100);
        sw_data = 16'h5A3C;
        press(3'b010, 1'b0, 10);
        model_press(3'b010);
        capture_display(segs, bad);
        checks++;
        if (segs !== expected_segs() || bad != 0) begin
            errors++;
            $display("[TB] FAIL ack_load: got %h (bad=%0d) expected %h", segs, bad, expected_segs());
        end
        press(3'b001, 1'b0, 10);
        model_press(3'b001);
        capture_display(segs, bad);
        checks++;
        if (segs !== expected_segs() || bad != 0) begin
            errors++;
            $display("[TB] FAIL ack_next_exit: got %h (bad=%0d) expected %h", segs, bad, expected_segs());
        end
        sw_data = 16'h0F0F;
        press(3'b010, 1'b0, 10);
        model_press(3'b010);
        capture_display(segs, bad);
        checks++;
        if (segs !== expected_segs() || bad != 0) begin
            errors++;
            $display("[TB] FAIL stage_after_ack: got %h (bad=%0d) expected %h", segs, bad, expected_segs());
        end
    endtask

    task automatic test_simultaneous();
        logic [63:0] segs;
        int bad;
        reg_admin_ena = 1'b1;
        sw_addr = 5'd9;
        sw_data = 16'h1357;
        press(3'b110, 1'b0, 10);
        model_press(3'b110);
        checks++;
        if ({reg_i, reg_input, led_err} !== expected_outs()) begin
            errors++;
            $display("[TB] FAIL load_write_outs: got %h expected %h", {reg_i, reg_input, led_err}, expected_outs());
        end
        repeat (AK + 10) @(negedge clk);
        m_mode = M_REG;
        sw_data = 16'h2468;
        press(3'b011, 1'b0, 10);
        model_press(3'b011);
        capture_display(segs, bad);
        checks++;
        if (segs !== expected_segs() || bad != 0) begin
            errors++;
            $display("[TB] FAIL next_load_display: got %h (bad=%0d) expected %h", segs, bad, expected_segs());
        end
        press(3'b001, 1'b0, 10);
        model_press(3'b001);
    endtask

    task automatic test_random();
        logic [63:0] segs;
        logic [2:0]  mask;
        int bad;
        for (int k = 0; k < NR; k++) oreg[32*k +: 32] = $urandom;
        for (int n = 0; n < 14; n++) begin
            mask          = 3'b001 << $urandom_range(0, 2);
            reg_admin_ena = 1'($urandom_range(0, 1));
            sw_data       = 16'($urandom);
            sw_addr       = 5'($urandom);
            press(mask, 1'($urandom_range(0, 1)), $urandom_range(10, 30));
            model_press(mask);
            checks++;
            if ({reg_i, reg_input, led_err} !== expected_outs()) begin
                errors++;
                $display("[TB] FAIL rand_outs[%0d]: got %h expected %h", n, {reg_i, reg_input, led_err}, expected_outs());
            end
            capture_display(segs, bad);
            checks++;
            if (segs !== expected_segs() || bad != 0) begin
                errors++;
                $display("[TB] FAIL rand_display[%0d]: got %h (bad=%0d) expected %h", n, segs, bad, expected_segs());
            end
            if (m_mode == M_ACK) begin
                repeat (AK) @(negedge clk);
                m_mode = M_REG;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] segs;
        int bad;
        reg_admin_ena = 1'b1;
        sw_addr = 5'd30;
        press(3'b100, 1'b0, 10);
        @(negedge clk);
        btn = 3'b001;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        checks++;
        if ({reg_i, reg_input, led_err} !== 38'd0) begin
            errors++;
            $display("[TB] FAIL midrst_outs: got %h expected 0", {reg_i, reg_input, led_err});
        end
        checks++;
        if (an !== 8'hFE || seg !== glyph_lut[oreg[3:0]]) begin
            errors++;
            $display("[TB] FAIL midrst_pins: got an=%h seg=%h expected an=fe seg=%h", an, seg, glyph_lut[oreg[3:0]]);
        end
        btn = 3'b000;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        capture_display(segs, bad);
        checks++;
        if (segs !== expected_segs() || bad != 0) begin
            errors++;
            $display("[TB] FAIL midrst_no_pulse: got %h (bad=%0d) expected %h", segs, bad, expected_segs());
        end
        sw_data = 16'hC0DE;
        press(3'b010, 1'b0, 10);
        model_press(3'b010);
        capture_display(segs, bad);
        checks++;
        if (segs !== expected_segs() || bad != 0) begin
            errors++;
            $display("[TB] FAIL midrst_stage: got %h (bad=%0d) expected %h", segs, bad, expected_segs());
        end
    endtask

    initial begin
        rst           = 1'b1;
        btn           = 3'b000;
        reg_admin_ena = 1'b0;
        sw_data       = '0;
        sw_addr       = '0;
        oreg[31:0]    = 32'h1234ABCD;
        oreg[63:32]   = 32'h0BADF00D;
        oreg[95:64]   = 32'h76543210;
        oreg[127:96]  = 32'hFEDCBA98;
        oreg[159:128] = 32'h13579BDF;
        model_reset();

        test_reset();
        test_next_glitch();
        test_load_stage();
        test_write_ack();
        test_refused();
        test_ack_buttons();
        test_simultaneous();
        test_random();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
